as_gpio_port: RTL and testbench

AS_GPIO_PORT -- requirements
Module: as_gpio_port

---
 rtl/as_pack.sv | 13 +
 rtl/as_gpio_fifo.sv | 60 ++++++
 rtl/as_gpio_port.sv | 117 +++++++++++
 tb/tb_as_gpio_port.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/as_pack.sv
// Shared types and default widths for the GPIO output port.
package as_pack;

   localparam int unsigned nr_gpios        = 8;
   localparam int unsigned gpio_addr_width = 8;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      GAP
   } gpio_state_e;

endpackage

// File: rtl/as_gpio_fifo.sv
// Synchronous write-buffer FIFO with occupancy count and asynchronous active-high reset.
module as_gpio_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [WIDTH-1:0]        wdata_i,
   output logic [WIDTH-1:0]        rdata_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
   localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
   localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i && (count_q != CntFull);
   assign pop_ok  = pop_i && (count_q != '0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage needs no reset: pointers and count define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // DEPTH is a power of two, so pointer wrap is the natural overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CntOne;
            2'b01:   count_q <= count_q - CntOne;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/as_gpio_port.sv
// Buffered GPIO output port: CPU stores are queued and replayed as single-cycle cs_o strobes.
// Optional shadow readback register rdata_o is built only when AS_GPIO_SHADOW_EN is defined.
module as_gpio_port
   import as_pack::*;
#(
   parameter int unsigned NR_GPIOS   = nr_gpios,
   parameter int unsigned ADDR_W     = gpio_addr_width,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [63:0]         wdata_i,
   output logic                stall_o,
   output logic [NR_GPIOS-1:0] gpio_o,
   output logic [ADDR_W-1:0]   gpioAddr_o,
   output logic                cs_o
`ifdef AS_GPIO_SHADOW_EN
   ,
   output logic [NR_GPIOS-1:0] rdata_o
`endif
);

   localparam int unsigned EntryW = ADDR_W + NR_GPIOS;
   localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [GapW-1:0] GapOne  = GapW'(1);

   gpio_state_e         state_q;
   logic [GapW-1:0]     gap_cnt_q;
   logic                cs_q;
   logic [NR_GPIOS-1:0] gpio_q;
   logic [ADDR_W-1:0]   addr_q;

   logic                push;
   logic                pop;
   logic [EntryW-1:0]   head;
   logic [CntW-1:0]     fifo_count;
   logic                unused_wdata;

   // Only the low NR_GPIOS data bits reach the pins.
   assign unused_wdata = ^wdata_i[63:NR_GPIOS];

   assign stall_o = (fifo_count == CntW'(FIFO_DEPTH));
   assign push    = we_i && !stall_o;
   assign pop     = (state_q == IDLE) && (fifo_count != '0);

   as_gpio_fifo #(
      .WIDTH (EntryW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({addr_i, wdata_i[NR_GPIOS-1:0]}),
      .rdata_o (head),
      .count_o (fifo_count)
   );

   // cs_o is registered on leaving DRIVE, giving the two-cycle store-to-strobe latency
   // and a strobe period of 2 + GAP_CYCLES under continuous traffic.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         gap_cnt_q <= '0;
         cs_q      <= 1'b0;
         gpio_q    <= '0;
         addr_q    <= '0;
      end else begin
         cs_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  {addr_q, gpio_q} <= head;
                  state_q          <= DRIVE;
               end
            end
            DRIVE: begin
               cs_q      <= 1'b1;
               gap_cnt_q <= '0;
               state_q   <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
               if (gap_cnt_q == GapLast) begin
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GapOne;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cs_o       = cs_q;
   assign gpio_o     = gpio_q;
   assign gpioAddr_o = addr_q;

`ifdef AS_GPIO_SHADOW_EN
   logic [NR_GPIOS-1:0] rdata_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (state_q == DRIVE) begin
         rdata_q <= gpio_q;
      end
   end

   assign rdata_o = rdata_q;
`endif

endmodule

// File: tb/tb_as_gpio_port.sv
// Randomized and directed bench for as_gpio_port against a queue-based timing model.
// Shadow readback checks are compiled in when AS_GPIO_SHADOW_EN is defined.
module tb_as_gpio_port;

   localparam int NR    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam int GAP   = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [63:0]   wdata = '0;
   logic          stall;
   logic [NR-1:0] gpio;
   logic [AW-1:0] gaddr;
   logic          cs;
`ifdef AS_GPIO_SHADOW_EN
   logic [NR-1:0] rdata;
`endif

   as_gpio_port #(
      .NR_GPIOS   (NR),
      .ADDR_W     (AW),
      .FIFO_DEPTH (DEPTH),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_i       (we),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .stall_o    (stall),
      .gpio_o     (gpio),
      .gpioAddr_o (gaddr),
      .cs_o       (cs)
`ifdef AS_GPIO_SHADOW_EN
      ,
      .rdata_o    (rdata)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: an entry may leave the queue once 2+GAP edges have passed since the
   // previous departure; its strobe is visible after the following edge.
   logic [AW+NR-1:0] mq[$];
   int               edge_no = 0;
   int               last_pop = -1000;
   logic [NR-1:0]    exp_gpio = '0;
   logic [AW-1:0]    exp_addr = '0;
   logic [NR-1:0]    exp_rdata = '0;
   logic             exp_cs = 1'b0;

   int               strobe_data[$];
   int               strobe_edge[$];

   function automatic void model_reset();
      mq.delete();
      last_pop  = -1000;
      exp_gpio  = '0;
      exp_addr  = '0;
      exp_rdata = '0;
      exp_cs    = 1'b0;
   endfunction

   function automatic void model_step(input logic w, input logic [AW-1:0] a,
                                      input logic [63:0] d);
      bit full;
      bit can_pop;
      full    = (mq.size() == DEPTH);
      can_pop = (mq.size() > 0) && (edge_no >= last_pop + 2 + GAP);
      exp_cs  = (edge_no == last_pop + 1);
      if (exp_cs) exp_rdata = exp_gpio;
      if (can_pop) begin
         {exp_addr, exp_gpio} = mq.pop_front();
         last_pop = edge_no;
      end
      if (w && !full) mq.push_back({a, d[NR-1:0]});
      edge_no++;
   endfunction

   task automatic cycle(input logic w, input logic [AW-1:0] a, input logic [63:0] d);
      we    = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      model_step(w, a, d);
      #1;
      check("cs", {63'd0, cs}, {63'd0, exp_cs});
      check("gpio", {56'd0, gpio}, {56'd0, exp_gpio});
      check("gpio_addr", {56'd0, gaddr}, {56'd0, exp_addr});
      check("stall", {63'd0, stall}, {63'd0, (mq.size() == DEPTH)});
      check("count", 64'(dut.fifo_count), 64'(mq.size()));
`ifdef AS_GPIO_SHADOW_EN
      check("rdata", {56'd0, rdata}, {56'd0, exp_rdata});
`endif
      if (cs === 1'b1) begin
         strobe_data.push_back(int'(gpio));
         strobe_edge.push_back(edge_no);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
   endtask

   // Hold the store until it is accepted, as the CPU would while stalled.
   task automatic store(input logic [AW-1:0] a, input logic [63:0] d);
      bit was_full;
      int tries;
      tries = 0;
      do begin
         was_full = (mq.size() == DEPTH);
         cycle(1'b1, a, d);
         tries++;
      end while (was_full && tries < 20);
      if (was_full) check("store_timeout", 64'(tries), 64'd0);
      we = 1'b0;
   endtask

   task automatic pulse_reset();
      we = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_cs", {63'd0, cs}, 64'd0);
      check("rst_gpio", {56'd0, gpio}, 64'd0);
      check("rst_addr", {56'd0, gaddr}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_count", 64'(dut.fifo_count), 64'd0);
      model_reset();
      @(posedge clk);
      edge_no++;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      bit stall_seen;
      int n_before;

      model_reset();
      #2;
      pulse_reset();
      idle(2);

      // Single store: strobe two edges later, then drops.
      cycle(1'b1, 8'd4, 64'd4);
      idle(1);
      cycle(1'b0, '0, '0);
      check("lat_cs", {63'd0, cs}, 64'd1);
      check("lat_addr", {56'd0, gaddr}, 64'd4);
      check("lat_gpio", {56'd0, gpio}, 64'd4);
      cycle(1'b0, '0, '0);
      check("lat_cs_drop", {63'd0, cs}, 64'd0);
      idle(4);
      check("hold_gpio", {56'd0, gpio}, 64'd4);

      // Upper data bits are discarded.
      store(8'h10, 64'h1_0000_0001);
      idle(4);
      check("trunc_gpio", {56'd0, gpio}, 64'h01);

      // Back-to-back stores fill the buffer; order and spacing must hold.
      strobe_data.delete();
      strobe_edge.delete();
      stall_seen = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         store(8'(i), 64'(i));
         if (stall === 1'b1) stall_seen = 1'b1;
      end
      idle(30);
      check("stall_seen", {63'd0, stall_seen}, 64'd1);
      check("strobe_count", 64'(strobe_data.size()), 64'd8);
      for (int i = 0; i < strobe_data.size(); i++) begin
         check("strobe_order", 64'(strobe_data[i]), 64'(i + 1));
         if (i > 0) check("strobe_gap", 64'(strobe_edge[i] - strobe_edge[i-1]), 64'(2 + GAP));
      end

      // Push and pop on the same edge with two entries buffered.
      cycle(1'b1, 8'h21, 64'h11);
      cycle(1'b1, 8'h22, 64'h12);
      cycle(1'b1, 8'h23, 64'h13);
      check("pp_pre", 64'(dut.fifo_count), 64'd2);
      idle(1);
      cycle(1'b1, 8'h24, 64'h14);
      check("pp_count", 64'(dut.fifo_count), 64'd2);
      idle(20);

      // Reset mid-operation with three entries buffered.
      cycle(1'b1, 8'h31, 64'h31);
      cycle(1'b1, 8'h32, 64'h32);
      cycle(1'b1, 8'h33, 64'h33);
      cycle(1'b1, 8'h34, 64'h34);
      check("mid_count", 64'(dut.fifo_count), 64'd3);
      pulse_reset();
      n_before = strobe_data.size();
      idle(15);
      check("post_rst_strobes", 64'(strobe_data.size()), 64'(n_before));

`ifdef AS_GPIO_SHADOW_EN
      store(8'h01, 64'hA5);
      store(8'h02, 64'h3C);
      idle(8);
      check("shadow", {56'd0, rdata}, 64'h3C);
`endif

      // Random traffic, including stores dropped while stalled.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 9) < 6), 8'($urandom), {$urandom, $urandom});
         if ($urandom_range(0, 199) == 0) pulse_reset();
      end
      idle(30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
